adc_sample_ctrl: RTL and testbench

Sequencer that drives the dual-channel SPI ADC interface at a fixed sample rate. Each conversion is started with a one-cycle enable pulse, and the block waits for the returned data-update strobe. It accumulates 2^AVG_LOG2 samples per channel and publishes the truncated averages with a one-cycle valid strobe to the multimeter measurement/display path. It sits between the ADC SPI front end and the measurement logic and owns conversion timing and error detection (timeout, overrun).

---
 rtl/adc_pkg.sv | 18 +
 rtl/adc_rate_div.sv | 27 ++
 rtl/adc_sample_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_adc_sample_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared types and helpers for the ADC sample sequencer.
package adc_pkg;

  localparam int ADC_W = 12;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TICK = 2'd1,
    REQ       = 2'd2,
    WAIT_DATA = 2'd3
  } state_t;

  // Clock cycles between conversion starts.
  function automatic int calc_div(input int clk_hz, input int sample_hz);
    return clk_hz / sample_hz;
  endfunction

endpackage

// File: rtl/adc_rate_div.sv
// Sample-rate tick generator. Counts 0..DIV-1 while en is high and pulses
// tick on the last count; en low holds the counter cleared.
module adc_rate_div #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Free-running modulo-DIV counter, cleared whenever disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           cnt <= '0;
    else if (!en)         cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + CW'(1);
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/adc_sample_ctrl.sv
// Dual-channel ADC conversion sequencer: paces conversion starts, collects
// 2^AVG_LOG2 samples per channel and publishes truncated window averages.
// Flags conversions that go unanswered (timeout) and rate ticks that land on
// a pending conversion (overrun).
// Optional: define ADC_MINMAX_EN to track channel-0 per-window min/max;
// otherwise min0_o/max0_o are tied to 0.
module adc_sample_ctrl
  import adc_pkg::*;
#(
  parameter int CLK_HZ      = 100_000_000,
  parameter int SAMPLE_HZ   = 10_000,
  parameter int AVG_LOG2    = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_i,
  output logic             adc_en_o,
  input  logic             adc_update_i,
  input  logic [ADC_W-1:0] adc_data0_i,
  input  logic [ADC_W-1:0] adc_data1_i,
  output logic [ADC_W-1:0] avg0_o,
  output logic [ADC_W-1:0] avg1_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic             timeout_o,
  output logic             overrun_o,
  output logic [ADC_W-1:0] min0_o,
  output logic [ADC_W-1:0] max0_o
);

  localparam int NUM_CH = 2;
  localparam int DIV    = calc_div(CLK_HZ, SAMPLE_HZ);
  localparam int ACC_W  = ADC_W + AVG_LOG2;
  localparam int CNT_W  = AVG_LOG2 + 1;
  localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LAST_SMP = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

  state_t state, state_nxt;

  logic             div_en, tick;
  logic             upd_ok, to_hit, win_done;
  logic [CNT_W-1:0] cnt;
  logic [TO_W-1:0]  tcnt;

  logic [NUM_CH-1:0][ADC_W-1:0] din, avg;
  logic [NUM_CH-1:0][ACC_W-1:0] acc, sum;

  // Divider only runs once the FSM has left IDLE, so the first tick lands
  // DIV cycles after run_i rises and adc_en_o one cycle later.
  assign div_en = run_i && (state != IDLE);

  adc_rate_div #(.DIV(DIV)) u_div (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (div_en),
    .tick (tick)
  );

  // tcnt holds the number of cycles elapsed since adc_en_o; on TO_LAST the
  // next edge would reach TIMEOUT_CYC, so an unanswered request expires here.
  // A coincident update wins over expiry.
  assign upd_ok   = run_i && (state == WAIT_DATA) && adc_update_i;
  assign to_hit   = run_i && (state == WAIT_DATA) && !adc_update_i && (tcnt >= TO_LAST);
  assign win_done = upd_ok && (cnt == LAST_SMP);

  assign adc_en_o = (state == REQ);
  assign busy_o   = (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; dropping run_i returns to IDLE from anywhere.
  always_comb begin
    state_nxt = state;
    if (!run_i) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:      state_nxt = WAIT_TICK;
        WAIT_TICK: if (tick) state_nxt = REQ;
        REQ:       state_nxt = WAIT_DATA;
        WAIT_DATA: if (adc_update_i || to_hit) state_nxt = WAIT_TICK;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  // Sample count, timeout counter, valid strobe and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      tcnt      <= '0;
      valid_o   <= 1'b0;
      timeout_o <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      valid_o <= win_done;

      if (!run_i || win_done) cnt <= '0;
      else if (upd_ok)        cnt <= cnt + CNT_W'(1);

      if (state == REQ)            tcnt <= TO_W'(1);
      else if (state == WAIT_DATA) tcnt <= tcnt + TO_W'(1);

      // IDLE with run_i high is exactly the cycle of a run_i rising edge.
      if (state == IDLE && run_i) begin
        timeout_o <= 1'b0;
        overrun_o <= 1'b0;
      end else begin
        if (to_hit)                       timeout_o <= 1'b1;
        if (tick && state != WAIT_TICK)   overrun_o <= 1'b1;
      end
    end
  end

  assign din = {adc_data1_i, adc_data0_i};

  // Per-channel running sum including the sample currently presented.
  always_comb begin
    sum = '0;
    for (int ch = 0; ch < NUM_CH; ch++)
      sum[ch] = acc[ch] + ACC_W'(din[ch]);
  end

  // Accumulate accepted samples; publish truncated averages on window end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      avg <= '0;
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (win_done) begin
          acc[ch] <= '0;
          avg[ch] <= ADC_W'(sum[ch] >> AVG_LOG2);
        end else if (!run_i) begin
          acc[ch] <= '0;
        end else if (upd_ok) begin
          acc[ch] <= sum[ch];
        end
      end
    end
  end

  assign avg0_o = avg[0];
  assign avg1_o = avg[1];

`ifdef ADC_MINMAX_EN
  logic [ADC_W-1:0] run_min, run_max, nmin, nmax;

  // Extremes including the current sample; the first sample of a window
  // reseeds both, so no explicit clear is needed between windows.
  always_comb begin
    nmin = run_min;
    nmax = run_max;
    if (cnt == '0) begin
      nmin = adc_data0_i;
      nmax = adc_data0_i;
    end else begin
      if (adc_data0_i < run_min) nmin = adc_data0_i;
      if (adc_data0_i > run_max) nmax = adc_data0_i;
    end
  end

  // Running extremes and their published copies, updated with the averages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_min <= '0;
      run_max <= '0;
      min0_o  <= '0;
      max0_o  <= '0;
    end else begin
      if (upd_ok) begin
        run_min <= nmin;
        run_max <= nmax;
      end
      if (win_done) begin
        min0_o <= nmin;
        max0_o <= nmax;
      end
    end
  end
`else
  assign min0_o = '0;
  assign max0_o = '0;
`endif

endmodule

// File: tb/tb_adc_sample_ctrl.sv
// Testbench for adc_sample_ctrl: DIV=10, 4-sample windows, timeout 8.
// A second instance with a 16-cycle timeout exercises overrun, which an
// 8-cycle timeout makes unreachable at DIV=10.
module tb_adc_sample_ctrl;

  localparam int CLK_HZ = 1000;
  localparam int SAMPLE_HZ = 100;
  localparam int DIV = 10;
  localparam int AVG_LOG2 = 2;
  localparam int NSMP = 4;
  localparam int TOUT = 8;

  logic clk = 1'b0;
  logic rst_n, run_a, run_b, sel_b;
  logic adc_update_i;
  logic [11:0] adc_data0_i, adc_data1_i;

  logic en_a, valid_a, busy_a, to_a, ov_a;
  logic [11:0] avg0_a, avg1_a, min0_a, max0_a;
  logic en_b, valid_b, busy_b, to_b, ov_b;
  logic [11:0] avg0_b, avg1_b, min0_b, max0_b;

  logic en_s, valid_s, to_s, ov_s;
  logic [11:0] avg0_s, avg1_s, min0_s, max0_s;

  int errors = 0, checks = 0, cyc = 0;
  int vcount, lv0, lv1, lmin, lmax, lvcyc, to_cyc, ov_cyc;
  int resp_lat, pend, last_avg0;
  int q0[$], q1[$], lat_q[$], en_q[$];
  logic to_prev = 1'b0, ov_prev = 1'b0;

  adc_sample_ctrl #(.CLK_HZ(CLK_HZ), .SAMPLE_HZ(SAMPLE_HZ), .AVG_LOG2(AVG_LOG2),
                    .TIMEOUT_CYC(TOUT)) dut (
    .clk(clk), .rst_n(rst_n), .run_i(run_a), .adc_en_o(en_a),
    .adc_update_i(adc_update_i), .adc_data0_i(adc_data0_i), .adc_data1_i(adc_data1_i),
    .avg0_o(avg0_a), .avg1_o(avg1_a), .valid_o(valid_a), .busy_o(busy_a),
    .timeout_o(to_a), .overrun_o(ov_a), .min0_o(min0_a), .max0_o(max0_a));

  adc_sample_ctrl #(.CLK_HZ(CLK_HZ), .SAMPLE_HZ(SAMPLE_HZ), .AVG_LOG2(AVG_LOG2),
                    .TIMEOUT_CYC(16)) dut_ovr (
    .clk(clk), .rst_n(rst_n), .run_i(run_b), .adc_en_o(en_b),
    .adc_update_i(adc_update_i), .adc_data0_i(adc_data0_i), .adc_data1_i(adc_data1_i),
    .avg0_o(avg0_b), .avg1_o(avg1_b), .valid_o(valid_b), .busy_o(busy_b),
    .timeout_o(to_b), .overrun_o(ov_b), .min0_o(min0_b), .max0_o(max0_b));

  assign en_s    = sel_b ? en_b    : en_a;
  assign valid_s = sel_b ? valid_b : valid_a;
  assign to_s    = sel_b ? to_b    : to_a;
  assign ov_s    = sel_b ? ov_b    : ov_a;
  assign avg0_s  = sel_b ? avg0_b  : avg0_a;
  assign avg1_s  = sel_b ? avg1_b  : avg1_a;
  assign min0_s  = sel_b ? min0_b  : min0_a;
  assign max0_s  = sel_b ? max0_b  : max0_a;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Front-end model: answers each adc_en_o after a latency (0 = never).
  initial begin
    adc_update_i = 1'b0;
    adc_data0_i = '0;
    adc_data1_i = '0;
    pend = 0;
    forever begin
      @(posedge clk); #1;
      adc_update_i = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          adc_update_i = 1'b1;
          if (q0.size() > 0) adc_data0_i = 12'(q0.pop_front());
          else adc_data0_i = 12'($urandom);
          if (q1.size() > 0) adc_data1_i = 12'(q1.pop_front());
          else adc_data1_i = 12'($urandom);
        end
      end
      if (en_s) begin
        if (lat_q.size() > 0) pend = lat_q.pop_front();
        else pend = resp_lat;
      end
    end
  end

  // Event log of the selected instance.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (en_s) en_q.push_back(cyc);
      if (valid_s) begin
        vcount++;
        lv0 = int'(avg0_s); lv1 = int'(avg1_s);
        lmin = int'(min0_s); lmax = int'(max0_s);
        lvcyc = cyc;
      end
      if (to_s && !to_prev) to_cyc = cyc;
      if (ov_s && !ov_prev) ov_cyc = cyc;
      to_prev = to_s;
      ov_prev = ov_s;
    end
  end

  task automatic clear_logs();
    en_q.delete(); q0.delete(); q1.delete(); lat_q.delete();
    vcount = 0; to_cyc = -1; ov_cyc = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run_a = 1'b0; run_b = 1'b0; sel_b = 1'b0; resp_lat = 3;
    clear_logs();
    repeat (3) @(negedge clk);
    checks++; if ({en_a, valid_a, busy_a, to_a, ov_a} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 00000", {en_a, valid_a, busy_a, to_a, ov_a}); end
    checks++; if (avg0_a !== 12'd0) begin errors++; $display("FAIL reset_avg0: got %0d want 0", avg0_a); end
    checks++; if (avg1_a !== 12'd0) begin errors++; $display("FAIL reset_avg1: got %0d want 0", avg1_a); end
    checks++; if ({min0_a, max0_a} !== 24'd0) begin errors++; $display("FAIL reset_minmax: got %0d/%0d want 0/0", min0_a, max0_a); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({busy_a, en_a} !== 2'b0) begin errors++; $display("FAIL idle_no_run: got %b want 00", {busy_a, en_a}); end
  endtask

  task automatic test_basic();
    int s0[4] = '{100, 104, 108, 112};
    int s1[4] = '{0, 1, 2, 3};
    int c, e0, e1;
    clear_logs();
    e0 = 0; e1 = 0;
    for (int i = 0; i < NSMP; i++) begin
      q0.push_back(s0[i]); q1.push_back(s1[i]); e0 += s0[i]; e1 += s1[i];
    end
    e0 = e0 / NSMP; e1 = e1 / NSMP;
    c = cyc; run_a = 1'b1;
    for (int i = 0; i < 80 && vcount < 1; i++) @(negedge clk);
    run_a = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (vcount !== 1) begin errors++; $display("FAIL basic_valid_count: got %0d want 1", vcount); end
    checks++; if (lv0 !== e0) begin errors++; $display("FAIL basic_avg0: got %0d want %0d", lv0, e0); end
    checks++; if (lv1 !== e1) begin errors++; $display("FAIL basic_avg1: got %0d want %0d", lv1, e1); end
    checks++; if (lvcyc !== c + (DIV + 1) + 3 * DIV + 3 + 1) begin
      errors++; $display("FAIL basic_valid_cycle: got %0d want %0d", lvcyc - c, (DIV + 1) + 3 * DIV + 4); end
    checks++; if (en_q.size() !== NSMP || en_q[0] !== c + DIV + 1) begin
      errors++; $display("FAIL basic_first_en: got n=%0d at +%0d want n=4 at +%0d", en_q.size(),
                         (en_q.size() > 0) ? en_q[0] - c : -1, DIV + 1); end
    checks++; if (en_q.size() < NSMP || en_q[3] - en_q[0] !== 3 * DIV) begin
      errors++; $display("FAIL basic_en_spacing: got %0d want %0d",
                         (en_q.size() >= NSMP) ? en_q[3] - en_q[0] : -1, 3 * DIV); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL basic_busy_after_stop: got %b want 0", busy_a); end
    last_avg0 = e0;
  endtask

  task automatic test_saturate();
    clear_logs();
    for (int i = 0; i < NSMP; i++) begin q0.push_back(4095); q1.push_back(4095); end
    run_a = 1'b1;
    for (int i = 0; i < 80 && vcount < 1; i++) @(negedge clk);
    run_a = 1'b0;
    @(negedge clk);
    checks++; if (vcount !== 1 || lv0 !== (4 * 4095) / NSMP) begin
      errors++; $display("FAIL sat_avg0: got %0d (n=%0d) want %0d", lv0, vcount, (4 * 4095) / NSMP); end
    checks++; if (lv1 !== (4 * 4095) / NSMP) begin errors++; $display("FAIL sat_avg1: got %0d want 4095", lv1); end
    last_avg0 = 4095;
  endtask

  // Three back-to-back windows with random data and latencies 1..7; the
  // first latency is 7 so the answer lands on the timeout expiry cycle.
  task automatic test_random();
    int e0[3], e1[3], ec[3], emn[3], emx[3];
    int c, s0, s1, lat, acc0, acc1;
    clear_logs();
    c = cyc;
    acc0 = 0; acc1 = 0;
    for (int i = 0; i < 3 * NSMP; i++) begin
      s0 = int'($urandom_range(0, 4095));
      s1 = int'($urandom_range(0, 4095));
      lat = (i == 0) ? 7 : (i == 3 * NSMP - 1) ? 1 : int'($urandom_range(1, 7));
      q0.push_back(s0); q1.push_back(s1); lat_q.push_back(lat);
      if (i % NSMP == 0) begin emn[i / NSMP] = s0; emx[i / NSMP] = s0; end
      if (s0 < emn[i / NSMP]) emn[i / NSMP] = s0;
      if (s0 > emx[i / NSMP]) emx[i / NSMP] = s0;
      acc0 += s0; acc1 += s1;
      if (i % NSMP == NSMP - 1) begin
        e0[i / NSMP] = acc0 / NSMP; e1[i / NSMP] = acc1 / NSMP;
        ec[i / NSMP] = c + DIV + 1 + DIV * i + lat + 1;
        acc0 = 0; acc1 = 0;
      end
    end
    run_a = 1'b1;
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < 60 && vcount <= w; i++) @(negedge clk);
      checks++; if (vcount !== w + 1 || lv0 !== e0[w] || lv1 !== e1[w]) begin
        errors++; $display("FAIL rand_avg w%0d: got %0d/%0d (n=%0d) want %0d/%0d", w, lv0, lv1, vcount, e0[w], e1[w]); end
      checks++; if (lvcyc !== ec[w]) begin
        errors++; $display("FAIL rand_valid_cycle w%0d: got +%0d want +%0d", w, lvcyc - c, ec[w] - c); end
`ifdef ADC_MINMAX_EN
      checks++; if (lmin !== emn[w] || lmax !== emx[w]) begin
        errors++; $display("FAIL rand_minmax w%0d: got %0d/%0d want %0d/%0d", w, lmin, lmax, emn[w], emx[w]); end
`else
      checks++; if (lmin !== 0 || lmax !== 0) begin
        errors++; $display("FAIL rand_minmax_off w%0d: got %0d/%0d want 0/0", w, lmin, lmax); end
`endif
    end
    run_a = 1'b0;
    @(negedge clk);
    checks++; if ({to_a, ov_a} !== 2'b00) begin
      errors++; $display("FAIL rand_no_flags: got %b want 00", {to_a, ov_a}); end
    last_avg0 = e0[2];
  endtask

  task automatic test_timeout();
    int c;
    clear_logs();
    resp_lat = 0;
    c = cyc; run_a = 1'b1;
    for (int i = 0; i < 40 && en_q.size() < 2; i++) @(negedge clk);
    checks++; if (to_cyc !== c + DIV + 1 + TOUT) begin
      errors++; $display("FAIL timeout_cycle: got +%0d want +%0d", to_cyc - c, DIV + 1 + TOUT); end
    checks++; if (en_q.size() < 2 || en_q[1] !== c + 2 * DIV + 1) begin
      errors++; $display("FAIL timeout_next_en: got +%0d want +%0d",
                         (en_q.size() >= 2) ? en_q[1] - c : -1, 2 * DIV + 1); end
    checks++; if (vcount !== 0) begin errors++; $display("FAIL timeout_no_valid: got %0d want 0", vcount); end
    run_a = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if ({to_a, busy_a} !== 2'b10) begin
      errors++; $display("FAIL timeout_sticky: got %b want 10", {to_a, busy_a}); end
    run_a = 1'b1;
    @(negedge clk);
    checks++; if (to_a !== 1'b0) begin errors++; $display("FAIL timeout_clear_on_run: got %b want 0", to_a); end
    run_a = 1'b0;
    resp_lat = 3;
    @(negedge clk);
  endtask

  task automatic test_overrun();
    int c, e0, e1, s;
    clear_logs();
    sel_b = 1'b1;
    resp_lat = 12;
    e0 = 0; e1 = 0;
    for (int i = 0; i < NSMP; i++) begin
      s = int'($urandom_range(0, 4095)); q0.push_back(s); e0 += s;
      s = int'($urandom_range(0, 4095)); q1.push_back(s); e1 += s;
    end
    e0 = e0 / NSMP; e1 = e1 / NSMP;
    c = cyc; run_b = 1'b1;
    for (int i = 0; i < 150 && vcount < 1; i++) @(negedge clk);
    run_b = 1'b0;
    checks++; if (ov_cyc !== c + 2 * DIV + 1) begin
      errors++; $display("FAIL overrun_cycle: got +%0d want +%0d", ov_cyc - c, 2 * DIV + 1); end
    checks++; if (en_q.size() < 2 || en_q[1] - en_q[0] !== 2 * DIV) begin
      errors++; $display("FAIL overrun_rate_lost: got %0d want %0d",
                         (en_q.size() >= 2) ? en_q[1] - en_q[0] : -1, 2 * DIV); end
    checks++; if (vcount !== 1 || lv0 !== e0 || lv1 !== e1) begin
      errors++; $display("FAIL overrun_avg: got %0d/%0d (n=%0d) want %0d/%0d", lv0, lv1, vcount, e0, e1); end
    checks++; if (lvcyc !== c + DIV + 1 + 3 * 2 * DIV + 12 + 1) begin
      errors++; $display("FAIL overrun_valid_cycle: got +%0d want +%0d", lvcyc - c, DIV + 1 + 6 * DIV + 13); end
    checks++; if ({ov_b, to_b} !== 2'b10) begin
      errors++; $display("FAIL overrun_flags: got %b want 10", {ov_b, to_b}); end
    @(negedge clk);
    sel_b = 1'b0;
    resp_lat = 3;
    @(negedge clk);
  endtask

  task automatic test_run_drop();
    int d, e0, s;
    clear_logs();
    for (int i = 0; i < 2; i++) begin
      q0.push_back(int'($urandom_range(0, 4095))); q1.push_back(int'($urandom_range(0, 4095)));
    end
    run_a = 1'b1;
    repeat (2 * DIV + 6) @(negedge clk);
    run_a = 1'b0;
    @(negedge clk);
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL drop_busy: got %b want 0", busy_a); end
    repeat (4) @(negedge clk);
    checks++; if (vcount !== 0 || avg0_a !== 12'(last_avg0)) begin
      errors++; $display("FAIL drop_retain: got avg0=%0d n=%0d want %0d n=0", avg0_a, vcount, last_avg0); end
    clear_logs();
    e0 = 0;
    for (int i = 0; i < NSMP; i++) begin
      s = int'($urandom_range(0, 4095)); q0.push_back(s); e0 += s;
      q1.push_back(int'($urandom_range(0, 4095)));
    end
    e0 = e0 / NSMP;
    d = cyc; run_a = 1'b1;
    repeat (4 * DIV) @(negedge clk);
    checks++; if (vcount !== 0 || avg0_a !== 12'(last_avg0)) begin
      errors++; $display("FAIL drop_partial_hold: got avg0=%0d n=%0d want %0d n=0", avg0_a, vcount, last_avg0); end
    for (int i = 0; i < 20 && vcount < 1; i++) @(negedge clk);
    run_a = 1'b0;
    checks++; if (vcount !== 1 || lv0 !== e0 || lvcyc !== d + DIV + 1 + 3 * DIV + 4) begin
      errors++; $display("FAIL drop_fresh_window: got %0d at +%0d (n=%0d) want %0d at +%0d",
                         lv0, lvcyc - d, vcount, e0, DIV + 1 + 3 * DIV + 4); end
    last_avg0 = e0;
    @(negedge clk);
  endtask

  task automatic test_minmax();
    int s0[4] = '{50, 10, 90, 30};
    int e0, emn, emx;
    clear_logs();
    e0 = 0; emn = s0[0]; emx = s0[0];
    for (int i = 0; i < NSMP; i++) begin
      q0.push_back(s0[i]); q1.push_back(int'($urandom_range(0, 4095)));
      e0 += s0[i];
      if (s0[i] < emn) emn = s0[i];
      if (s0[i] > emx) emx = s0[i];
    end
    e0 = e0 / NSMP;
`ifndef ADC_MINMAX_EN
    emn = 0; emx = 0;
`endif
    run_a = 1'b1;
    for (int i = 0; i < 80 && vcount < 1; i++) @(negedge clk);
    run_a = 1'b0;
    checks++; if (vcount !== 1 || lv0 !== e0) begin
      errors++; $display("FAIL mm_avg0: got %0d (n=%0d) want %0d", lv0, vcount, e0); end
    checks++; if (lmin !== emn) begin errors++; $display("FAIL mm_min0: got %0d want %0d", lmin, emn); end
    checks++; if (lmax !== emx) begin errors++; $display("FAIL mm_max0: got %0d want %0d", lmax, emx); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_random();
    test_timeout();
    test_overrun();
    test_run_drop();
    test_minmax();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
